// File: rtl/fu_sequencer.sv
// fu_sequencer: multi-cycle controller that drives an external combinational
// 32-bit ALU from a small register file.
//
// Each accepted command walks IDLE -> EXEC -> WB. In IDLE the two source
// operands are registered onto the ALU inputs. EXEC holds them steady for a
// full cycle so the combinational ALU can settle. WB captures G and the flags,
// and writes G to rd when wb is set.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake; ready depends only on the state
//   cmd_gsel/rd/ra/rb  ALU function code and register addresses
//   cmd_wb             1 = write result to rd, 0 = flags-only (compare)
//   ld_en/addr/data    direct register load, allowed in any state
//   alu_a/b/gsel       registered operands and function code to the ALU
//   alu_g, alu_z/n/c/v ALU result and flags
//   done               one-cycle pulse in the WB cycle
//   result, flags      last captured G and {Z,N,C,V}
//   dbg_addr/data      combinational register file read port
module fu_sequencer #(
    parameter int DW = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_gsel,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic          cmd_wb,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_gsel,
    input  logic [DW-1:0] alu_g,
    input  logic          alu_z,
    input  logic          alu_n,
    input  logic          alu_c,
    input  logic          alu_v,
    output logic          done,
    output logic [DW-1:0] result,
    output logic [3:0]    flags,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int NREG = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_rf [NREG];
    logic [AW-1:0] r_rd;
    logic          r_wb;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [3:0]    r_gsel;
    logic [DW-1:0] r_result;
    logic [3:0]    r_flags;
    logic          r_done;

    logic w_accept;
    logic w_wb_write;

    assign cmd_ready  = (r_state == S_IDLE);
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_wb_write = (r_state == S_WB) & r_wb;

    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign alu_gsel = r_gsel;
    assign done     = r_done;
    assign result   = r_result;
    assign flags    = r_flags;
    assign dbg_data = r_rf[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rd     <= '0;
            r_wb     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_gsel   <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Operands come from pre-edge contents, so a load
                        // landing on this same edge is not seen here.
                        r_a     <= r_rf[cmd_ra];
                        r_b     <= r_rf[cmd_rb];
                        r_gsel  <= cmd_gsel;
                        r_rd    <= cmd_rd;
                        r_wb    <= cmd_wb;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // done is registered so it lines up with the WB cycle.
                    r_done  <= 1'b1;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_result <= alu_g;
                    r_flags  <= {alu_z, alu_n, alu_c, alu_v};
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Write-back has priority over a direct load to the same entry;
            // loads to other entries proceed in parallel.
            for (int i = 0; i < NREG; i++) begin
                if (w_wb_write && r_rd == AW'(i))
                    r_rf[i] <= alu_g;
                else if (ld_en && ld_addr == AW'(i))
                    r_rf[i] <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_fu_sequencer.sv
module tb_fu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_gsel;
    logic [2:0]  cmd_rd, cmd_ra, cmd_rb;
    logic        cmd_wb;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] alu_a, alu_b, alu_g;
    logic [3:0]  alu_gsel;
    logic        alu_z, alu_n, alu_c, alu_v;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fu_sequencer #(.DW(32), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_gsel(cmd_gsel), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_wb(cmd_wb),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_gsel(alu_gsel),
        .alu_g(alu_g), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .done(done), .result(result), .flags(flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference combinational ALU (the block under test only sequences it).
    logic [31:0] m_bb;
    logic        m_cin, m_arith;
    logic [32:0] m_s;
    always_comb begin
        m_bb = '0; m_cin = 1'b0; m_arith = 1'b1; m_s = '0;
        case (alu_gsel)
            4'b0001: m_cin = 1'b1;
            4'b0010: m_bb = alu_b;
            4'b0011: begin m_bb = alu_b; m_cin = 1'b1; end
            4'b0100: m_bb = ~alu_b;
            4'b0101: begin m_bb = ~alu_b; m_cin = 1'b1; end
            4'b0110: m_bb = 32'hFFFF_FFFF;
            default: m_arith = 1'b0;
        endcase
        if (m_arith)
            m_s = {1'b0, alu_a} + {1'b0, m_bb} + {32'b0, m_cin};
        else
            case (alu_gsel)
                4'b1000: m_s = {1'b0, alu_a & alu_b};
                4'b1010: m_s = {1'b0, alu_a | alu_b};
                4'b1100: m_s = {1'b0, alu_a ^ alu_b};
                4'b1110: m_s = {1'b0, ~alu_a};
                default: m_s = {1'b0, alu_a};
            endcase
        alu_g = m_s[31:0];
        alu_z = (m_s[31:0] == 32'b0);
        alu_n = m_s[31];
        alu_c = m_arith & m_s[32];
        alu_v = m_arith & (alu_a[31] == m_bb[31]) & (m_s[31] != alu_a[31]);
    end

    typedef struct {
        logic [3:0]  gsel;
        logic [2:0]  ra, rb, rd;
        logic        wb;
        logic [31:0] exp_g;
        logic [3:0]  exp_f;    // {Z,N,C,V}
        logic [31:0] exp_rdv;  // rf[rd] after retirement
    } vec_t;

    typedef struct {
        logic [31:0] g;
        logic [3:0]  f;
        logic [2:0]  rd;
        logic [31:0] rdv;
        int          acc;
    } sb_t;

    sb_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(name, dbg_data, exp);
    endtask

    // Present a command and return at the negedge after it is accepted.
    // Optional load is driven onto the accept edge.
    task automatic issue(input vec_t v, input bit push, input bit ld,
                         input logic [2:0] la, input logic [31:0] ldd, output int acc);
        int n = 0;
        cmd_gsel = v.gsel; cmd_ra = v.ra; cmd_rb = v.rb; cmd_rd = v.rd; cmd_wb = v.wb;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
        acc = cyc;
        if (push) sbq.push_back('{v.exp_g, v.exp_f, v.rd, v.exp_rdv, acc});
        ld_en = ld; ld_addr = la; ld_data = ldd;
        @(posedge clk);
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Scoreboard: pop at done, compare captured state one cycle later.
    initial begin
        sb_t cur;
        bit  pend = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                pend = 0;
                chk("result", result, cur.g);
                chk("flags", 32'(flags), 32'(cur.f));
                chk_reg("rf_rd", cur.rd, cur.rdv);
            end
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: got done=1 expected no retirement (cycle %0d)", cyc);
                end else begin
                    cur = sbq.pop_front();
                    chk("done_latency", 32'(cyc - cur.acc), 32'd2);
                    pend = 1;
                end
            end
        end
    end

    vec_t tbl[7];
    int   accs[7];

    initial begin
        int   a;
        vec_t v;

        tbl[0] = '{4'b0010, 3'd1, 3'd2, 3'd3, 1'b1, 32'hFFFF_FFFF, 4'b0100, 32'hFFFF_FFFF};
        tbl[1] = '{4'b0101, 3'd4, 3'd4, 3'd5, 1'b0, 32'h0000_0000, 4'b1010, 32'h0000_0000};
        tbl[2] = '{4'b0010, 3'd3, 3'd4, 3'd5, 1'b1, 32'h0000_0004, 4'b0010, 32'h0000_0004};
        tbl[3] = '{4'b1000, 3'd1, 3'd2, 3'd6, 1'b1, 32'h0000_0000, 4'b1000, 32'h0000_0000};
        tbl[4] = '{4'b1100, 3'd1, 3'd2, 3'd7, 1'b1, 32'hFFFF_FFFF, 4'b0100, 32'hFFFF_FFFF};
        tbl[5] = '{4'b0101, 3'd1, 3'd2, 3'd0, 1'b1, 32'hB4B4_B4B5, 4'b0101, 32'hB4B4_B4B5};
        tbl[6] = '{4'b0010, 3'd0, 3'd0, 3'd0, 1'b1, 32'h6969_696A, 4'b0011, 32'h6969_696A};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_gsel = '0; cmd_rd = '0; cmd_ra = '0;
        cmd_rb = '0; cmd_wb = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_gsel", 32'(alu_gsel), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        for (int i = 0; i < 8; i++) chk_reg("rst_rf", 3'(i), 32'd0);

        load(3'd1, 32'h5A5A_5A5A);
        load(3'd2, 32'hA5A5_A5A5);
        load(3'd4, 32'h0000_0005);

        // Table, back-to-back with cmd_valid held high throughout
        for (int i = 0; i < 7; i++) begin
            issue(tbl[i], 1'b1, 1'b0, 3'd0, 32'd0, a);
            accs[i] = a;
        end
        cmd_valid = 1'b0;
        for (int i = 1; i < 7; i++) chk("accept_spacing", 32'(accs[i] - accs[i-1]), 32'd3);
        repeat (3) @(negedge clk);

        // Collision: WB to r6 wins over same-edge load to r6
        v = '{4'b0010, 3'd1, 3'd2, 3'd6, 1'b1, 32'hFFFF_FFFF, 4'b0100, 32'hFFFF_FFFF};
        issue(v, 1'b1, 1'b0, 3'd0, 32'd0, a);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("wb_done", 32'(done), 32'd1);
        ld_en = 1'b1; ld_addr = 3'd6; ld_data = 32'h1234_5678;
        @(negedge clk);
        ld_en = 1'b0;

        // Different addresses: both land
        v = '{4'b1100, 3'd1, 3'd1, 3'd6, 1'b1, 32'h0000_0000, 4'b1000, 32'h0000_0000};
        issue(v, 1'b1, 1'b0, 3'd0, 32'd0, a);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("wb_done2", 32'(done), 32'd1);
        ld_en = 1'b1; ld_addr = 3'd7; ld_data = 32'h1234_5678;
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
        chk_reg("ld_other", 3'd7, 32'h1234_5678);

        // Same-edge load to ra does not affect the operand
        v = '{4'b0010, 3'd1, 3'd2, 3'd3, 1'b1, 32'hFFFF_FFFF, 4'b0100, 32'hFFFF_FFFF};
        issue(v, 1'b1, 1'b1, 3'd1, 32'h0000_0000, a);
        cmd_valid = 1'b0;
        chk("same_edge_a", alu_a, 32'h5A5A_5A5A);
        repeat (3) @(negedge clk);
        chk_reg("same_edge_ld", 3'd1, 32'h0000_0000);

        // Reset during EXEC
        v = '{4'b0010, 3'd2, 3'd2, 3'd4, 1'b1, 32'h0, 4'b0, 32'h0};
        issue(v, 1'b0, 1'b0, 3'd0, 32'd0, a);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_flags", 32'(flags), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) chk_reg("mid_rst_rf", 3'(i), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk_reg("post_rst_r4", 3'd4, 32'd0);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/fu_sequencer.md
Name: fu_sequencer

Overview:
- Multi-cycle controller that sequences the 32-bit function unit (ALU with 4-bit Gselect and Z/N/C/V flags) against a small register file.
- Accepts one command per handshake, reads two source registers, drives the ALU, then captures the result and flags and optionally writes back.
- Sits between an instruction source (test harness or future decoder) and the combinational ALU, which is instantiated outside this block.

Parameters:
- DW, 32, datapath width; must match the ALU width.
- AW, 3, register address width; the register file holds 2**AW entries.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_gsel  input  4  ALU function code, passed unchanged to the ALU.
- cmd_rd  input  AW  destination register.
- cmd_ra  input  AW  source register for ALU port A.
- cmd_rb  input  AW  source register for ALU port B.
- cmd_wb  input  1  1 = write result to rd; 0 = flags-only (compare) operation.
- ld_en  input  1  direct register load strobe.
- ld_addr  input  AW  load address.
- ld_data  input  DW  load data.
- alu_a  output  DW  to ALU A.
- alu_b  output  DW  to ALU B.
- alu_gsel  output  4  to ALU Gselect.
- alu_g  input  DW  ALU result G.
- alu_z, alu_n, alu_c, alu_v  input  1 each  ALU flags.
- done  output  1  one-cycle pulse when an operation retires.
- result  output  DW  last captured G.
- flags  output  4  last captured {Z,N,C,V}; bit 3 = Z.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  DW  combinational read of the register file at dbg_addr.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - alu_a, alu_b, alu_gsel, result, flags = 0; done = 0.
  - All registers = 0.
  - cmd_ready asserts once reset is released.
- FSM states: IDLE, EXEC, WB.
  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready:
    - Register alu_a <= rf[ra], alu_b <= rf[rb], alu_gsel <= cmd_gsel.
    - Latch rd and wb.
    - Next state EXEC.
  - EXEC: cmd_ready = 0. Registered operands are stable at the ALU for a full cycle (the ALU is combinational). Next state WB.
  - WB: cmd_ready = 0.
    - At the end of the cycle: result <= alu_g; flags <= {alu_z, alu_n, alu_c, alu_v}; if wb then rf[rd] <= alu_g.
    - done = 1 for this cycle only.
    - Next state IDLE.
- Timing:
  - Latency: accept edge to done = 2 cycles; result, flags and the register write are visible the cycle after done.
  - Throughput: one command every 3 cycles.
  - cmd_ready is a function of state only; it never depends on cmd_valid.
- Operand read: sampled at the accept edge using pre-edge contents. A same-edge ld_en to ra or rb does not affect the operands.
- Loads: ld_en writes rf[ld_addr] <= ld_data in any state.
  - Same edge as a WB write to the same address: the WB write wins and the load is dropped.
  - Different addresses: both writes occur.
- Outputs hold between operations:
  - alu_a, alu_b and alu_gsel keep their last values in IDLE.
  - result and flags hold until the next WB.
  - flags-only commands (wb=0) update result and flags but not the register file.
- Register 0 is an ordinary register; rd = ra = rb is legal.
- Reset mid-operation: immediate return to IDLE. The in-flight command is discarded, no write and no done pulse; the register file is cleared.
- cmd_valid while busy: ignored. The source must hold the command until cmd_ready.

Test Plan:
- Load r1=5A5A5A5A, r2=A5A5A5A5; cmd gsel=0010 (A+B), ra=1, rb=2, rd=3, wb=1 -> done 2 cycles after accept; r3=FFFFFFFF; flags Z=0 N=1 C=0 V=0; cmd_ready low for exactly 2 cycles.
- Load r4=00000005; cmd gsel=0101 (A+~B+1), ra=rb=4, rd=5, wb=0 -> result=00000000, flags Z=1 C=1; r5 unchanged (0).
- Back-to-back: cmd_valid held high with two commands -> accepts 3 cycles apart; the second command reads the first's written rd (r3 fed back as ra) and sees FFFFFFFF.
- Collision: during WB of a cmd with rd=6, assert ld_en ld_addr=6 ld_data=12345678 -> r6 = ALU result. Repeat with ld_addr=7 -> both r6 and r7 are written.
- Same-edge load: ld_en to r1=00000000 on the accept edge of an A+B using ra=1 -> operand alu_a = old 5A5A5A5A.
- Assert rst_n=0 during EXEC -> no done, no write, outputs 0, register file 0; cmd_ready=1 the cycle after release.
